// File: rtl/rvm_mem_arbiter_if.sv
// SRAM-style memory port bundle shared by requesters and the arbiter.
// master drives the request (addr/wdata/c_en/w_en/b_en); slave returns rdata/error/stall.
interface rvm_mem_arbiter_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_c_en;
    logic        mem_w_en;
    logic [3:0]  mem_b_en;
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        mem_stall;

    modport master (
        output mem_addr, mem_wdata, mem_c_en, mem_w_en, mem_b_en,
        input  mem_rdata, mem_error, mem_stall
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_c_en, mem_w_en, mem_b_en,
        output mem_rdata, mem_error, mem_stall
    );
endinterface

// File: rtl/rvm_mem_arbiter.sv
// Two-requester arbiter sharing one SRAM-style memory port, transaction-atomic grants.
// Ports: ACLK, ARESETn, p0/p1 (requester slave ports), s (shared master port), owner (00/01/10).
module rvm_mem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    rvm_mem_arbiter_if.slave        p0,
    rvm_mem_arbiter_if.slave        p1,
    rvm_mem_arbiter_if.master       s,
    output logic [1:0]              owner
);

    // Encoding doubles as the owner status value.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   rr_q, rr_d;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;

        s.mem_addr  = '0;
        s.mem_wdata = '0;
        s.mem_c_en  = 1'b0;
        s.mem_w_en  = 1'b0;
        s.mem_b_en  = '0;

        // A requesting port is held off unless it owns the bus.
        p0.mem_rdata = s.mem_rdata;
        p0.mem_error = 1'b0;
        p0.mem_stall = p0.mem_c_en;
        p1.mem_rdata = s.mem_rdata;
        p1.mem_error = 1'b0;
        p1.mem_stall = p1.mem_c_en;

        unique case (state_q)
            IDLE: begin
                if (p0.mem_c_en && p1.mem_c_en) begin
                    state_d = (FIXED_PRIO || !rr_q) ? OWN0 : OWN1;
                end else if (p0.mem_c_en) begin
                    state_d = OWN0;
                end else if (p1.mem_c_en) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                s.mem_addr   = p0.mem_addr;
                s.mem_wdata  = p0.mem_wdata;
                s.mem_c_en   = p0.mem_c_en;
                s.mem_w_en   = p0.mem_w_en;
                s.mem_b_en   = p0.mem_b_en;
                p0.mem_stall = s.mem_stall;
                p0.mem_error = s.mem_error;
                // Abort releases the bus but keeps the pointer.
                if (!p0.mem_c_en) begin
                    state_d = IDLE;
                end else if (!s.mem_stall) begin
                    state_d = IDLE;
                    rr_d    = 1'b1;
                end
            end
            OWN1: begin
                s.mem_addr   = p1.mem_addr;
                s.mem_wdata  = p1.mem_wdata;
                s.mem_c_en   = p1.mem_c_en;
                s.mem_w_en   = p1.mem_w_en;
                s.mem_b_en   = p1.mem_b_en;
                p1.mem_stall = s.mem_stall;
                p1.mem_error = s.mem_error;
                if (!p1.mem_c_en) begin
                    state_d = IDLE;
                end else if (!s.mem_stall) begin
                    state_d = IDLE;
                    rr_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign owner = state_q;

endmodule

// File: tb/tb_rvm_mem_arbiter.sv
// Directed self-checking bench for rvm_mem_arbiter (round-robin and fixed-priority).
// Ports exercised through interface instances; slave side driven by hand.
module tb_rvm_mem_arbiter;

    logic       ACLK;
    logic       ARESETn;
    logic [1:0] owner_a;
    logic [1:0] owner_b;

    int n_chk;
    int n_fail;

    rvm_mem_arbiter_if p0a ();
    rvm_mem_arbiter_if p1a ();
    rvm_mem_arbiter_if sa  ();
    rvm_mem_arbiter_if p0b ();
    rvm_mem_arbiter_if p1b ();
    rvm_mem_arbiter_if sb  ();

    rvm_mem_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .p0      (p0a),
        .p1      (p1a),
        .s       (sa),
        .owner   (owner_a)
    );

    rvm_mem_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .p0      (p0b),
        .p1      (p1b),
        .s       (sb),
        .owner   (owner_b)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance past a rising edge; inputs change here, checks follow #1 later.
    task automatic cyc();
        @(posedge ACLK);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        ARESETn = 1'b0;
        p0a.mem_addr = '0; p0a.mem_wdata = '0; p0a.mem_c_en = 1'b0;
        p0a.mem_w_en = 1'b0; p0a.mem_b_en = '0;
        p1a.mem_addr = '0; p1a.mem_wdata = '0; p1a.mem_c_en = 1'b0;
        p1a.mem_w_en = 1'b0; p1a.mem_b_en = '0;
        sa.mem_rdata = '0; sa.mem_error = 1'b0; sa.mem_stall = 1'b0;
        p0b.mem_addr = '0; p0b.mem_wdata = '0; p0b.mem_c_en = 1'b0;
        p0b.mem_w_en = 1'b0; p0b.mem_b_en = '0;
        p1b.mem_addr = '0; p1b.mem_wdata = '0; p1b.mem_c_en = 1'b0;
        p1b.mem_w_en = 1'b0; p1b.mem_b_en = '0;
        sb.mem_rdata = '0; sb.mem_error = 1'b0; sb.mem_stall = 1'b0;

        // Reset state
        #3;
        chk("rst_owner", 32'(owner_a), 32'h0);
        chk("rst_s_cen", 32'(sa.mem_c_en), 32'h0);
        chk("rst_s_addr", sa.mem_addr, 32'h0);
        chk("rst_p0_stall_idle", 32'(p0a.mem_stall), 32'h0);
        p0a.mem_c_en = 1'b1;
        settle();
        chk("rst_p0_stall_req", 32'(p0a.mem_stall), 32'h1);
        chk("rst_p0_err", 32'(p0a.mem_error), 32'h0);
        p0a.mem_c_en = 1'b0;
        cyc();
        ARESETn = 1'b1;
        cyc();

        // 1: p0 read with 3 downstream stall cycles
        p0a.mem_addr = 32'h100; p0a.mem_c_en = 1'b1;
        sa.mem_stall = 1'b1;
        settle();
        chk("t1_arb_stall", 32'(p0a.mem_stall), 32'h1);
        chk("t1_arb_owner", 32'(owner_a), 32'h0);
        chk("t1_arb_scen", 32'(sa.mem_c_en), 32'h0);
        chk("t1_arb_p1stall", 32'(p1a.mem_stall), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            settle();
            chk("t1_own_owner", 32'(owner_a), 32'h1);
            chk("t1_own_addr", sa.mem_addr, 32'h100);
            chk("t1_own_stall", 32'(p0a.mem_stall), 32'h1);
            chk("t1_own_p1stall", 32'(p1a.mem_stall), 32'h0);
        end
        cyc();
        sa.mem_stall = 1'b0; sa.mem_rdata = 32'hDEADBEEF;
        settle();
        chk("t1_done_stall", 32'(p0a.mem_stall), 32'h0);
        chk("t1_done_rdata", p0a.mem_rdata, 32'hDEADBEEF);
        chk("t1_done_owner", 32'(owner_a), 32'h1);
        cyc();
        p0a.mem_c_en = 1'b0;
        settle();
        chk("t1_idle_owner", 32'(owner_a), 32'h0);

        // 2: round-robin alternation after a fresh reset
        ARESETn = 1'b0;
        cyc();
        ARESETn = 1'b1;
        p0a.mem_addr = 32'h10; p0a.mem_c_en = 1'b1;
        p1a.mem_addr = 32'h20; p1a.mem_c_en = 1'b1;
        sa.mem_stall = 1'b0; sa.mem_rdata = 32'h0;
        settle();
        chk("t2_c0_owner", 32'(owner_a), 32'h0);
        cyc(); settle();
        chk("t2_c1_addr", sa.mem_addr, 32'h10);
        chk("t2_c1_p1stall", 32'(p1a.mem_stall), 32'h1);
        chk("t2_c1_p0stall", 32'(p0a.mem_stall), 32'h0);
        cyc(); settle();
        chk("t2_c2_owner", 32'(owner_a), 32'h0);
        chk("t2_c2_scen", 32'(sa.mem_c_en), 32'h0);
        cyc(); settle();
        chk("t2_c3_addr", sa.mem_addr, 32'h20);
        chk("t2_c3_owner", 32'(owner_a), 32'h2);
        cyc(); settle();
        chk("t2_c4_owner", 32'(owner_a), 32'h0);
        cyc(); settle();
        chk("t2_c5_addr", sa.mem_addr, 32'h10);
        cyc();
        p0a.mem_c_en = 1'b0; p1a.mem_c_en = 1'b0;

        // 3: fixed priority, both requesting continuously
        p0b.mem_addr = 32'h10; p0b.mem_c_en = 1'b1;
        p1b.mem_addr = 32'h20; p1b.mem_c_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("t3_owner", 32'(owner_b), (i % 2 == 0) ? 32'h0 : 32'h1);
            chk("t3_p1stall", 32'(p1b.mem_stall), 32'h1);
            cyc();
        end
        p0b.mem_c_en = 1'b0; p1b.mem_c_en = 1'b0;

        // 4: p1 write completing with error (pointer is 1 after p0 finished)
        p1a.mem_addr = 32'h40; p1a.mem_wdata = 32'hA5A5A5A5;
        p1a.mem_b_en = 4'b0011; p1a.mem_w_en = 1'b1; p1a.mem_c_en = 1'b1;
        sa.mem_stall = 1'b0; sa.mem_error = 1'b1;
        settle();
        chk("t4_idle_p1err", 32'(p1a.mem_error), 32'h0);
        chk("t4_idle_p1stall", 32'(p1a.mem_stall), 32'h1);
        cyc(); settle();
        chk("t4_owner", 32'(owner_a), 32'h2);
        chk("t4_wen", 32'(sa.mem_w_en), 32'h1);
        chk("t4_ben", 32'(sa.mem_b_en), 32'h3);
        chk("t4_wdata", sa.mem_wdata, 32'hA5A5A5A5);
        chk("t4_p1err", 32'(p1a.mem_error), 32'h1);
        chk("t4_p0err", 32'(p0a.mem_error), 32'h0);
        chk("t4_p1stall", 32'(p1a.mem_stall), 32'h0);
        cyc();
        p1a.mem_c_en = 1'b0; p1a.mem_w_en = 1'b0; p1a.mem_b_en = '0;
        settle();
        chk("t4_after_p1err", 32'(p1a.mem_error), 32'h0);
        sa.mem_error = 1'b0;

        // 5: p0 aborts under downstream stall; pending p1 then granted
        p0a.mem_addr = 32'h10; p0a.mem_c_en = 1'b1;
        sa.mem_stall = 1'b1;
        cyc();
        p1a.mem_addr = 32'h20; p1a.mem_c_en = 1'b1;
        settle();
        chk("t5_own0", 32'(owner_a), 32'h1);
        chk("t5_p1stall", 32'(p1a.mem_stall), 32'h1);
        cyc();
        p0a.mem_c_en = 1'b0;
        settle();
        chk("t5_abort_scen", 32'(sa.mem_c_en), 32'h0);
        cyc(); settle();
        chk("t5_idle_owner", 32'(owner_a), 32'h0);
        chk("t5_idle_scen", 32'(sa.mem_c_en), 32'h0);
        cyc();
        sa.mem_stall = 1'b0;
        settle();
        chk("t5_own1", 32'(owner_a), 32'h2);
        chk("t5_own1_addr", sa.mem_addr, 32'h20);
        chk("t5_p1done", 32'(p1a.mem_stall), 32'h0);
        cyc();
        p1a.mem_c_en = 1'b0;

        // Move pointer to 1 with a quick p0 read
        p0a.mem_c_en = 1'b1;
        cyc(); settle();
        chk("t6_pre_own0", 32'(owner_a), 32'h1);
        cyc();
        p0a.mem_c_en = 1'b0;

        // 6: reset mid OWN1 write
        p1a.mem_addr = 32'h40; p1a.mem_w_en = 1'b1; p1a.mem_c_en = 1'b1;
        sa.mem_stall = 1'b1;
        cyc(); settle();
        chk("t6_own1", 32'(owner_a), 32'h2);
        chk("t6_own1_scen", 32'(sa.mem_c_en), 32'h1);
        ARESETn = 1'b0;
        settle();
        chk("t6_rst_scen", 32'(sa.mem_c_en), 32'h0);
        chk("t6_rst_owner", 32'(owner_a), 32'h0);
        chk("t6_rst_p1stall", 32'(p1a.mem_stall), 32'h1);
        cyc();
        ARESETn = 1'b1;
        p1a.mem_w_en = 1'b0;
        p0a.mem_c_en = 1'b1;
        sa.mem_stall = 1'b0;
        settle();
        chk("t6_post_owner", 32'(owner_a), 32'h0);
        cyc(); settle();
        chk("t6_first_grant", 32'(owner_a), 32'h1);
        chk("t6_first_addr", sa.mem_addr, 32'h10);
        cyc();
        p0a.mem_c_en = 1'b0; p1a.mem_c_en = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
